// File: rtl/window_ctrl.sv
// window_ctrl: streaming 3x3 window generator over four circular row buffers
module window_ctrl #(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [PIX_W-1:0]   i_pixel,
  input  logic               i_pixel_valid,
  output logic               o_in_ready,
  output logic [9*PIX_W-1:0] o_window,
  output logic               o_window_valid,
  input  logic               i_out_ready,
  output logic               o_row_done,
  output logic               o_overflow
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam logic [CW-1:0] COL_END = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 3);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nxt;
  logic [PIX_W-1:0] mem [4][IMAGE_WIDTH];
  logic [CW-1:0] wr_col, rd_col;
  logic [1:0] wr_buf, rd_buf;
  logic [2:0] rows_avail;
  logic last_q, wr_en, wr_wrap, enter, adv, load, rel;
  logic [9*PIX_W-1:0] win_nxt;
  assign o_in_ready = rows_avail != 3'd4;
  assign wr_en = i_pixel_valid && o_in_ready;
  assign wr_wrap = wr_en && wr_col == COL_END;
  assign enter = state == IDLE && rows_avail >= 3'd3;
  assign adv = state == READ && (!o_window_valid || i_out_ready);
  assign load = adv && rd_col <= COL_LAST;
  assign rel = o_window_valid && i_out_ready && last_q;
  assign o_row_done = rel;
  // row r of the window comes from buffer rd_buf+r, wrapping over the four buffers
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_nxt[PIX_W*(3*r+c) +: PIX_W] = mem[rd_buf + 2'(r)][rd_col + CW'(c)];
  end
  always_comb begin
    state_nxt = rel ? IDLE : enter ? READ : state;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_buf][wr_col] <= i_pixel;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_col <= '0;
      wr_buf <= '0;
      rd_col <= '0;
      rd_buf <= '0;
      rows_avail <= '0;
      last_q <= 1'b0;
      o_window <= '0;
      o_window_valid <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_col <= wr_wrap ? '0 : wr_col + 1'b1;
      if (wr_wrap) wr_buf <= wr_buf + 1'b1;
      rows_avail <= rows_avail + {2'b0, wr_wrap} - {2'b0, rel};
      if (i_pixel_valid && !o_in_ready) o_overflow <= 1'b1;
      if (enter) rd_col <= '0;
      if (load) begin
        o_window <= win_nxt;
        rd_col <= rd_col + 1'b1;
        last_q <= rd_col == COL_LAST;
      end
      if (adv) o_window_valid <= load;
      if (rel) rd_buf <= rd_buf + 1'b1;
    end
  end
endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: directed checks of the 3x3 window generator at IMAGE_WIDTH=8
module tb_window_ctrl;
  logic clk = 0, rstN = 1, pv = 0, rdy = 0;
  logic [7:0] pix = 0;
  logic o_in_ready, o_window_valid, o_row_done, o_overflow;
  logic [71:0] o_window;
  int total = 0, bad = 0, ready_low = 0, cyc_n = 0;
  logic [71:0] wq[$];
  logic dq[$];
  int tq[$];
  always #5 clk = ~clk;
  window_ctrl #(.IMAGE_WIDTH(8), .PIX_W(8)) dut (
    .clk(clk), .rstN(rstN), .i_pixel(pix), .i_pixel_valid(pv), .o_in_ready(o_in_ready),
    .o_window(o_window), .o_window_valid(o_window_valid), .i_out_ready(rdy),
    .o_row_done(o_row_done), .o_overflow(o_overflow));
  function automatic logic [71:0] exp_win3(input int a, input int b, input int c, input int col);
    logic [71:0] w;
    int rr;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      rr = (r == 0) ? a : (r == 1) ? b : c;
      for (int k = 0; k < 3; k++) w[8*(3*r+k) +: 8] = {4'(rr), 4'(col + k)};
    end
    return w;
  endfunction
  function automatic logic [71:0] exp_win(input int top, input int col);
    return exp_win3(top, top + 1, top + 2, col);
  endfunction
  task automatic cyc(input logic v, input logic [7:0] p, input logic r);
    @(negedge clk);
    pv = v;
    pix = p;
    rdy = r;
    #1;
    cyc_n++;
    if (!o_in_ready) ready_low++;
    if (o_window_valid && rdy) begin
      wq.push_back(o_window);
      dq.push_back(o_row_done);
      tq.push_back(cyc_n);
    end
  endtask
  task automatic write_row(input int row, input logic r);
    for (int c = 0; c < 8; c++) cyc(1'b1, 8'(row * 16 + c), r);
  endtask
  task automatic drain(input int n, input logic r);
    repeat (n) cyc(1'b0, 8'h00, r);
  endtask
  task automatic reset_dut;
    @(negedge clk);
    pv = 0;
    rdy = 0;
    rstN = 0;
    @(negedge clk);
    rstN = 1;
    wq.delete();
    dq.delete();
    tq.delete();
    ready_low = 0;
  endtask
  task automatic test_reset;
    rstN = 1;
    #1 rstN = 0;
    #1;
    total++;
    if (o_window !== '0 || o_window_valid !== 0 || o_row_done !== 0 || o_overflow !== 0 || o_in_ready !== 1) begin
      bad++;
      $display("FAIL reset_state got win=%h v=%b done=%b ovf=%b rdy=%b exp 0/0/0/0/1", o_window, o_window_valid, o_row_done, o_overflow, o_in_ready);
    end
    @(negedge clk);
    rstN = 1;
  endtask
  task automatic test_basic;
    int l;
    reset_dut;
    for (int r = 0; r < 3; r++) write_row(r, 1'b1);
    l = cyc_n;
    drain(20, 1'b1);
    total++;
    if (wq.size() !== 6) begin bad++; $display("FAIL basic_count got=%0d exp=6", wq.size()); end
    if (wq.size() == 6) begin
      total++;
      if (wq[0] !== 72'h22_21_20_12_11_10_02_01_00) begin bad++; $display("FAIL basic_first got=%h", wq[0]); end
      total++;
      if (wq[5] !== 72'h27_26_25_17_16_15_07_06_05) begin bad++; $display("FAIL basic_last got=%h", wq[5]); end
      total++;
      if (tq[0] !== l + 3 || tq[5] - tq[0] !== 5) begin bad++; $display("FAIL basic_timing got first=%0d span=%0d exp first=%0d span=5", tq[0], tq[5] - tq[0], l + 3); end
      for (int i = 0; i < 6; i++) begin
        total++;
        if (wq[i] !== exp_win(0, i) || dq[i] !== (i == 5)) begin bad++; $display("FAIL basic_win%0d got=%h done=%b exp=%h done=%b", i, wq[i], dq[i], exp_win(0, i), i == 5); end
      end
    end
    total++;
    if (o_window_valid !== 0) begin bad++; $display("FAIL basic_idle got valid=%b exp 0", o_window_valid); end
  endtask
  task automatic test_stream;
    reset_dut;
    for (int r = 0; r < 5; r++) write_row(r, 1'b1);
    drain(40, 1'b1);
    total++;
    if (wq.size() !== 18) begin bad++; $display("FAIL stream_count got=%0d exp=18", wq.size()); end
    if (wq.size() == 18) begin
      total++;
      if (wq[6] !== 72'h32_31_30_22_21_20_12_11_10) begin bad++; $display("FAIL stream_w7 got=%h", wq[6]); end
      for (int i = 0; i < 18; i++) begin
        total++;
        if (wq[i] !== exp_win(i / 6, i % 6) || dq[i] !== (i % 6 == 5)) begin bad++; $display("FAIL stream_win%0d got=%h done=%b exp=%h", i, wq[i], dq[i], exp_win(i / 6, i % 6)); end
      end
    end
    total++;
    if (ready_low !== 0 || o_overflow !== 0) begin bad++; $display("FAIL stream_flow got ready_low=%0d ovf=%b exp 0/0", ready_low, o_overflow); end
  endtask
  task automatic test_toggle;
    logic pend;
    logic [71:0] held;
    int n;
    reset_dut;
    pend = 0;
    held = '0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < 24) cyc(1'b1, 8'((i / 8) * 16 + i % 8), 1'(n % 2));
      else cyc(1'b0, 8'h00, 1'(n % 2));
      n++;
      if (pend) begin
        total++;
        if (!o_window_valid || o_window !== held) begin bad++; $display("FAIL toggle_hold cyc%0d got v=%b %h exp v=1 %h", i, o_window_valid, o_window, held); end
      end
      pend = o_window_valid && !rdy;
      held = o_window;
    end
    total++;
    if (wq.size() !== 6) begin bad++; $display("FAIL toggle_count got=%0d exp=6", wq.size()); end
    if (wq.size() == 6)
      for (int i = 0; i < 6; i++) begin
        total++;
        if (wq[i] !== exp_win(0, i) || dq[i] !== (i == 5)) begin bad++; $display("FAIL toggle_win%0d got=%h exp=%h", i, wq[i], exp_win(0, i)); end
      end
  endtask
  task automatic test_backpressure;
    reset_dut;
    for (int r = 0; r < 5; r++) write_row(r, 1'b0);
    total++;
    if (ready_low !== 8 || o_in_ready !== 0 || o_overflow !== 1 || o_window_valid !== 1 || wq.size() !== 0) begin
      bad++;
      $display("FAIL bp_stall got low=%0d rdy=%b ovf=%b v=%b n=%0d exp 8/0/1/1/0", ready_low, o_in_ready, o_overflow, o_window_valid, wq.size());
    end
    drain(30, 1'b1);
    total++;
    if (wq.size() !== 12 || o_window_valid !== 0 || o_in_ready !== 1 || o_overflow !== 1) begin
      bad++;
      $display("FAIL bp_drain got n=%0d v=%b rdy=%b ovf=%b exp 12/0/1/1", wq.size(), o_window_valid, o_in_ready, o_overflow);
    end
    if (wq.size() == 12)
      for (int i = 0; i < 12; i++) begin
        total++;
        if (wq[i] !== exp_win(i / 6, i % 6) || dq[i] !== (i % 6 == 5)) begin bad++; $display("FAIL bp_win%0d got=%h exp=%h", i, wq[i], exp_win(i / 6, i % 6)); end
      end
    write_row(9, 1'b1);
    drain(20, 1'b1);
    total++;
    if (wq.size() !== 18) begin bad++; $display("FAIL bp_resume_count got=%0d exp=18", wq.size()); end
    if (wq.size() == 18) begin
      total++;
      if (wq[12] !== exp_win3(2, 3, 9, 0) || wq[17] !== exp_win3(2, 3, 9, 5)) begin bad++; $display("FAIL bp_resume got=%h %h exp=%h %h", wq[12], wq[17], exp_win3(2, 3, 9, 0), exp_win3(2, 3, 9, 5)); end
    end
  endtask
  task automatic test_back_to_back;
    reset_dut;
    for (int r = 0; r < 3; r++) write_row(r, 1'b0);
    for (int c = 0; c < 8; c++) cyc(1'b1, 8'(48 + c), c >= 2);
    total++;
    if (wq.size() !== 6 || ready_low !== 0) begin bad++; $display("FAIL coin_count got=%0d low=%0d exp 6/0", wq.size(), ready_low); end
    if (wq.size() == 6) begin
      total++;
      if (dq[5] !== 1 || dq[4] !== 0 || wq[5] !== exp_win(0, 5)) begin bad++; $display("FAIL coin_done got done=%b%b w=%h", dq[4], dq[5], wq[5]); end
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (o_window_valid !== 0) begin bad++; $display("FAIL coin_idle1 got v=%b exp 0", o_window_valid); end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (o_window_valid !== 0) begin bad++; $display("FAIL coin_idle2 got v=%b exp 0", o_window_valid); end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (o_window_valid !== 1 || o_window !== exp_win(1, 0) || o_in_ready !== 1) begin
      bad++;
      $display("FAIL coin_next got v=%b w=%h rdy=%b exp v=1 w=%h rdy=1", o_window_valid, o_window, o_in_ready, exp_win(1, 0));
    end
  endtask
  task automatic test_reset_mid;
    reset_dut;
    for (int r = 0; r < 4; r++) write_row(r, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'(64 + c), 1'b0);
    total++;
    if (o_window_valid !== 1 || o_overflow !== 1 || o_in_ready !== 0) begin bad++; $display("FAIL rst_pre got v=%b ovf=%b rdy=%b exp 1/1/0", o_window_valid, o_overflow, o_in_ready); end
    #1 rstN = 0;
    #1;
    total++;
    if (o_window !== '0 || o_window_valid !== 0 || o_row_done !== 0 || o_overflow !== 0 || o_in_ready !== 1) begin
      bad++;
      $display("FAIL rst_async got win=%h v=%b done=%b ovf=%b rdy=%b exp 0/0/0/0/1", o_window, o_window_valid, o_row_done, o_overflow, o_in_ready);
    end
    pv = 0;
    @(negedge clk);
    rstN = 1;
    wq.delete();
    dq.delete();
    tq.delete();
    for (int r = 5; r < 8; r++) write_row(r, 1'b1);
    drain(15, 1'b1);
    total++;
    if (wq.size() !== 6) begin bad++; $display("FAIL rst_resume_count got=%0d exp=6", wq.size()); end
    if (wq.size() == 6) begin
      total++;
      if (wq[0] !== exp_win3(5, 6, 7, 0) || wq[5] !== exp_win3(5, 6, 7, 5)) begin bad++; $display("FAIL rst_resume got=%h %h exp=%h %h", wq[0], wq[5], exp_win3(5, 6, 7, 0), exp_win3(5, 6, 7, 5)); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_stream;
    test_toggle;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
